// File: rtl/pizza_pkg.sv
// Shared types and screen geometry for the pizza sprite motion logic.
`timescale 1ns/1ps
package pizza_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ROLL    = 2'd1,
    ST_FALL    = 2'd2,
    ST_RESPAWN = 2'd3
  } pizza_state_e;

  localparam int SPRITE_SIZE = 32;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;

endpackage

// File: rtl/pizza_respawn_timer.sv
// Frame counter used while the pizza is despawned; done marks the last waiting frame.
`timescale 1ns/1ps
module pizza_respawn_timer #(
  parameter int RESPAWN_FR = 60,
  localparam int CW = (RESPAWN_FR > 1) ? $clog2(RESPAWN_FR) : 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic done
);

  logic [CW-1:0] cnt;

  assign done = (cnt == CW'(RESPAWN_FR - 1));

  // Wraps to zero on the exit tick so the next despawn starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pizza_motion_ctrl.sv
// Per-frame motion sequencer for the rolling pizza sprite: roll, fall, wall bounce,
// despawn on hit or bottom of screen, and delayed respawn at the start point.
`timescale 1ns/1ps
module pizza_motion_ctrl
  import pizza_pkg::*;
#(
  parameter int H_START    = 40,
  parameter int V_START    = 40,
  parameter int H_MIN      = 0,
  parameter int H_MAX      = SCREEN_W - SPRITE_SIZE,
  parameter int V_MAX      = SCREEN_H - SPRITE_SIZE,
  parameter int ROLL_STEP  = 2,
  parameter int FALL_STEP  = 4,
  parameter int RESPAWN_FR = 60
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_tick,
  input  logic         enable,
  input  logic         on_floor,
  input  logic         hit,
  output logic [9:0]   curr_h,
  output logic [9:0]   curr_v,
  output logic         bounds_draw,
  output logic         dir_left,
  output pizza_state_e state_dbg
);

  localparam logic [9:0]  H_START10  = 10'(H_START);
  localparam logic [9:0]  V_START10  = 10'(V_START);
  localparam logic [9:0]  H_MIN10    = 10'(H_MIN);
  localparam logic [9:0]  H_MAX10    = 10'(H_MAX);
  localparam logic [9:0]  V_MAX10    = 10'(V_MAX);
  localparam logic [9:0]  ROLL10     = 10'(ROLL_STEP);
  localparam logic [10:0] H_MAX11    = 11'(H_MAX);
  localparam logic [10:0] V_MAX11    = 11'(V_MAX);
  localparam logic [10:0] H_LEFT_LIM = 11'(H_MIN + ROLL_STEP);

  pizza_state_e state;
  logic         respawn_done;
  logic [10:0]  h_ext;
  logic [10:0]  h_inc;
  logic [10:0]  v_inc;

  assign state_dbg = state;

  // Sums carry an extra bit so clamps near the right/bottom edge never wrap.
  assign h_ext = {1'b0, curr_h};
  assign h_inc = h_ext + 11'(ROLL_STEP);
  assign v_inc = {1'b0, curr_v} + 11'(FALL_STEP);

  pizza_respawn_timer #(
    .RESPAWN_FR (RESPAWN_FR)
  ) u_respawn_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != ST_RESPAWN),
    .tick  (frame_tick),
    .done  (respawn_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      curr_h      <= H_START10;
      curr_v      <= V_START10;
      dir_left    <= 1'b0;
      bounds_draw <= 1'b0;
    end else if (!enable) begin
      state       <= ST_IDLE;
      curr_h      <= H_START10;
      curr_v      <= V_START10;
      dir_left    <= 1'b0;
      bounds_draw <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_tick) begin
            state       <= ST_ROLL;
            curr_h      <= H_START10;
            curr_v      <= V_START10;
            dir_left    <= 1'b0;
            bounds_draw <= 1'b1;
          end
        end
        ST_ROLL: begin
          if (hit) begin
            state       <= ST_RESPAWN;
            bounds_draw <= 1'b0;
          end else if (frame_tick) begin
            if (!on_floor) begin
              state <= ST_FALL;
            end else if (!dir_left) begin
              if (h_inc >= H_MAX11) begin
                curr_h   <= H_MAX10;
                dir_left <= 1'b1;
              end else begin
                curr_h <= h_inc[9:0];
              end
            end else begin
              if (h_ext <= H_LEFT_LIM) begin
                curr_h   <= H_MIN10;
                dir_left <= 1'b0;
              end else begin
                curr_h <= curr_h - ROLL10;
              end
            end
          end
        end
        ST_FALL: begin
          if (hit) begin
            state       <= ST_RESPAWN;
            bounds_draw <= 1'b0;
          end else if (frame_tick) begin
            // Landing reverses direction; no movement on the landing frame.
            if (on_floor) begin
              state    <= ST_ROLL;
              dir_left <= ~dir_left;
            end else if (v_inc >= V_MAX11) begin
              curr_v      <= V_MAX10;
              state       <= ST_RESPAWN;
              bounds_draw <= 1'b0;
            end else begin
              curr_v <= v_inc[9:0];
            end
          end
        end
        ST_RESPAWN: begin
          if (frame_tick && respawn_done) begin
            state       <= ST_ROLL;
            curr_h      <= H_START10;
            curr_v      <= V_START10;
            dir_left    <= 1'b0;
            bounds_draw <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pizza_motion_ctrl.sv
// Directed and randomized checks of pizza_motion_ctrl against a frame-level reference model.
`timescale 1ns/1ps
module tb_pizza_motion_ctrl;
  import pizza_pkg::*;

  localparam int H_START    = 40;
  localparam int V_START    = 40;
  localparam int H_MAX      = 608;
  localparam int V_MAX      = 448;
  localparam int RESPAWN_FR = 60;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_tick = 1'b0;
  logic enable = 1'b0;
  logic on_floor = 1'b0;
  logic hit = 1'b0;

  logic [9:0]   curr_h;
  logic [9:0]   curr_v;
  logic         bounds_draw;
  logic         dir_left;
  pizza_state_e state_dbg;

  always #20 clk = ~clk;

  pizza_motion_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .on_floor    (on_floor),
    .hit         (hit),
    .curr_h      (curr_h),
    .curr_v      (curr_v),
    .bounds_draw (bounds_draw),
    .dir_left    (dir_left),
    .state_dbg   (state_dbg)
  );

  // ---------------- reference model ----------------
  pizza_state_e m_st;
  int           m_h;
  int           m_v;
  int           m_wait;
  bit           m_left;

  logic [23:0] exp_q[$];
  int          n_checks;
  int          n_pass;
  string       cur_tag;

  task automatic model_start_pos();
    m_h    = H_START;
    m_v    = V_START;
    m_left = 1'b0;
  endtask

  task automatic model_reset();
    m_st   = ST_IDLE;
    m_wait = 0;
    model_start_pos();
  endtask

  task automatic model_despawn();
    m_st   = ST_RESPAWN;
    m_wait = RESPAWN_FR;
  endtask

  task automatic model_clock(input bit tk, input bit en, input bit fl, input bit ht);
    if (!en) begin
      model_reset();
    end else begin
      case (m_st)
        ST_IDLE: if (tk) begin m_st = ST_ROLL; model_start_pos(); end
        ST_ROLL: begin
          if (ht) model_despawn();
          else if (tk) begin
            if (!fl) m_st = ST_FALL;
            else if (!m_left) begin
              m_h = (m_h + 2 > H_MAX) ? H_MAX : m_h + 2;
              if (m_h == H_MAX) m_left = 1'b1;
            end else begin
              m_h = (m_h - 2 < 0) ? 0 : m_h - 2;
              if (m_h == 0) m_left = 1'b0;
            end
          end
        end
        ST_FALL: begin
          if (ht) model_despawn();
          else if (tk) begin
            if (fl) begin
              m_st   = ST_ROLL;
              m_left = !m_left;
            end else begin
              m_v = (m_v + 4 > V_MAX) ? V_MAX : m_v + 4;
              if (m_v == V_MAX) model_despawn();
            end
          end
        end
        default: begin
          if (tk) begin
            m_wait = m_wait - 1;
            if (m_wait == 0) begin m_st = ST_ROLL; model_start_pos(); end
          end
        end
      endcase
    end
  endtask

  function automatic logic [23:0] model_pack();
    logic vis;
    vis = (m_st == ST_ROLL) || (m_st == ST_FALL);
    return {m_st, m_left, vis, m_v[9:0], m_h[9:0]};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic score();
    logic [23:0] e;
    logic [23:0] o;
    e = exp_q.pop_front();
    o = {state_dbg, dir_left, bounds_draw, curr_v, curr_h};
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got st=%0d dl=%0b bd=%0b v=%0d h=%0d, expected st=%0d dl=%0b bd=%0b v=%0d h=%0d",
                cur_tag, o[23:22], o[21], o[20], o[19:10], o[9:0],
                e[23:22], e[21], e[20], e[19:10], e[9:0]);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit tk, input bit en, input bit fl, input bit ht);
    frame_tick = tk;
    enable     = en;
    on_floor   = fl;
    hit        = ht;
    model_clock(tk, en, fl, ht);
    exp_q.push_back(model_pack());
    @(posedge clk);
    @(negedge clk);
    score();
  endtask

  task automatic tick(input bit fl);
    drive(1'b1, 1'b1, fl, 1'b0);
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(model_pack());
    score();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_reset();

    // Reset state
    cur_tag = "reset";
    async_reset_pulse();
    check("reset_h", 32'(curr_h), 32'd40);
    check("reset_bd", 32'(bounds_draw), 32'd0);

    // Start rolling right from the start point
    cur_tag = "roll_right";
    tick(1'b1);
    check("roll_first_h", 32'(curr_h), 32'd40);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1);
      check("roll_step_h", 32'(curr_h), 32'(40 + 2 * i));
    end
    cur_tag = "no_tick_hold";
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    check("hold_h", 32'(curr_h), 32'd50);

    // Step off, land again (direction flips), roll to the left wall
    cur_tag = "left_wall";
    tick(1'b0);
    check("fall_entry_state", 32'(state_dbg), 32'(ST_FALL));
    check("fall_entry_h", 32'(curr_h), 32'd50);
    tick(1'b1);
    check("land_dir_left", 32'(dir_left), 32'd1);
    for (int i = 0; i < 40 && m_h != 0; i++) tick(1'b1);
    check("left_wall_h", 32'(curr_h), 32'd0);
    check("left_wall_dir", 32'(dir_left), 32'd0);
    tick(1'b1);
    check("left_bounce_h", 32'(curr_h), 32'd2);

    // Right wall clamp and bounce
    cur_tag = "right_wall";
    for (int i = 0; i < 400 && m_h != 606; i++) tick(1'b1);
    check("pre_wall_h", 32'(curr_h), 32'd606);
    tick(1'b1);
    check("right_wall_h", 32'(curr_h), 32'd608);
    check("right_wall_dir", 32'(dir_left), 32'd1);
    tick(1'b1);
    check("right_bounce_h", 32'(curr_h), 32'd606);

    // Asynchronous reset in the middle of rolling
    cur_tag = "mid_roll_reset";
    async_reset_pulse();
    check("mid_reset_h", 32'(curr_h), 32'd40);
    check("mid_reset_v", 32'(curr_v), 32'd40);
    check("mid_reset_state", 32'(state_dbg), 32'(ST_IDLE));

    // Fall to the bottom, despawn, wait out the respawn delay
    cur_tag = "fall_bottom";
    tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 200 && m_v != 440; i++) tick(1'b0);
    check("fall_v440", 32'(curr_v), 32'd440);
    tick(1'b1);
    tick(1'b0);
    check("refall_no_move_v", 32'(curr_v), 32'd440);
    check("refall_state", 32'(state_dbg), 32'(ST_FALL));
    tick(1'b0);
    check("fall_v444", 32'(curr_v), 32'd444);
    tick(1'b0);
    check("fall_v448", 32'(curr_v), 32'd448);
    check("despawn_bd", 32'(bounds_draw), 32'd0);
    check("despawn_state", 32'(state_dbg), 32'(ST_RESPAWN));
    cur_tag = "respawn_wait";
    for (int i = 0; i < RESPAWN_FR - 1; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick(1'($urandom_range(0, 1)));
    end
    check("wait_bd", 32'(bounds_draw), 32'd0);
    tick(1'b1);
    check("respawn_h", 32'(curr_h), 32'd40);
    check("respawn_v", 32'(curr_v), 32'd40);
    check("respawn_bd", 32'(bounds_draw), 32'd1);

    // Hit coinciding with a frame tick while rolling
    cur_tag = "hit_tick_roll";
    tick(1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    check("hit_state", 32'(state_dbg), 32'(ST_RESPAWN));
    check("hit_h_frozen", 32'(curr_h), 32'd42);
    for (int i = 0; i < RESPAWN_FR && m_st == ST_RESPAWN; i++) tick(1'b1);
    check("hit_respawn_state", 32'(state_dbg), 32'(ST_ROLL));

    // Enable drop and hit in the same cycle while falling
    cur_tag = "enable_low_fall";
    tick(1'b0);
    tick(1'b0);
    tick(1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    check("en_low_state", 32'(state_dbg), 32'(ST_IDLE));
    check("en_low_v", 32'(curr_v), 32'd40);
    check("en_low_bd", 32'(bounds_draw), 32'd0);

    // Randomized traffic against the model
    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      drive(1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 99) < 98),
            1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 99) < 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
